// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo-core definitions used by the CDB arbiter and its bench.
//   ROB_TAG_W : width of a reorder-buffer index (16-entry ROB)
//   XLEN      : result value width
//   FU_*      : requester index assigned to each functional unit on the CDB
//   rr_next   : round-robin successor with an explicit wrap at n, so the
//               pointer stays correct when n is not a power of two
package tomasulo_pkg;

  localparam int ROB_TAG_W = 4;
  localparam int XLEN      = 32;

  localparam int FU_ADD = 0;
  localparam int FU_MUL = 1;
  localparam int FU_LD  = 2;
  localparam int FU_BR  = 3;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// The search starts at i_ptr and ascends, wrapping modulo NUM_REQ.
// The first requester with i_valid set wins.
//   i_valid : per-requester request flags
//   i_ptr   : highest-priority requester index (expected < NUM_REQ)
//   i_en    : when low, nothing is granted
//   o_grant : one-hot grant, or all zero
//   o_idx   : index of the granted requester (0 when none)
//   o_any   : a grant was issued
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [SRC_W-1:0]   i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [SRC_W-1:0]   o_idx,
  output logic               o_any
);

  // The position being examined is ptr+k folded back into range.
  // The inner loop matches that position against constant indices, so no
  // variable-width index is needed.
  always_comb begin
    int w_pos;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = 0;
    if (i_en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_pos = int'(i_ptr) + k;
        if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
          if (!o_any && (j == w_pos) && i_valid[j]) begin
            o_any      = 1'b1;
            o_grant[j] = 1'b1;
            o_idx      = SRC_W'(j);
          end
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter.
// It grants at most one completed functional-unit result per cycle, in
// round-robin order, and broadcasts the result one cycle later on a
// registered bus. A flush kills the grant in the current cycle, so nothing
// is broadcast in the following cycle.
//   clk, rst_n    : clock, synchronous active-low reset
//   flush         : misprediction flush, active high
//   req_valid     : per-FU result valid
//   req_tag       : per-FU ROB index; requester i is at [i*TAG_W +: TAG_W]
//   req_data      : per-FU result value, packed the same way
//   req_ready     : per-FU accept (combinational, one-hot or zero)
//   cdb_valid     : registered broadcast valid
//   cdb_tag       : broadcast ROB index
//   cdb_data      : broadcast value
//   cdb_src       : index of the requester being broadcast
//   grant_ptr     : round-robin priority pointer
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = XLEN,
  parameter int TAG_W   = ROB_TAG_W,
  parameter int SRC_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src,
  output logic [SRC_W-1:0]          grant_ptr
);

  logic               r_valid;
  logic [TAG_W-1:0]   r_tag;
  logic [DATA_W-1:0]  r_data;
  logic [SRC_W-1:0]   r_src;
  logic [SRC_W-1:0]   r_ptr;

  logic [NUM_REQ-1:0] w_grant;
  logic [SRC_W-1:0]   w_idx;
  logic               w_any;
  logic               w_en;
  logic [TAG_W-1:0]   w_tag;
  logic [DATA_W-1:0]  w_data;

  // Reset and flush both block the grant, so a flush cycle neither
  // accepts a result nor moves the pointer.
  assign w_en = rst_n & ~flush;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_en),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_tag  = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_tag  = req_tag[i*TAG_W +: TAG_W];
        w_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
      r_src   <= '0;
      r_ptr   <= '0;
    end else begin
      r_valid <= w_any;
      if (w_any) begin
        r_tag  <= w_tag;
        r_data <= w_data;
        r_src  <= w_idx;
        r_ptr  <= SRC_W'(rr_next(int'(w_idx), NUM_REQ));
      end
    end
  end

  assign req_ready = w_grant;
  assign cdb_valid = r_valid;
  assign cdb_tag   = r_tag;
  assign cdb_data  = r_data;
  assign cdb_src   = r_src;
  assign grant_ptr = r_ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import tomasulo_pkg::*;

  localparam int N  = 4;
  localparam int TW = 4;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [1:0]      cdb_src;
  logic [1:0]      grant_ptr;

  cdb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TAG_W(TW), .SRC_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src),
    .grant_ptr (grant_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: what the bus should show after the next edge.
  int          m_ptr;
  bit          m_valid;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_data;
  int          m_src;
  int          m_win;

  function automatic int model_pick(input logic [N-1:0] v, input int ptr,
                                    input logic fl, input logic rn);
    if (!rn || fl) return -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready(input int win);
    logic [N-1:0] r;
    r = '0;
    if (win >= 0) r[win] = 1'b1;
    return r;
  endfunction

  task automatic set_req(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
    req_tag[i*TW +: TW]  = t;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic at_neg();
    @(negedge clk);
    m_win = model_pick(req_valid, m_ptr, flush, rst_n);
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_valid = 0; m_tag = '0; m_data = '0; m_src = 0; m_ptr = 0;
    end else begin
      m_valid = (m_win >= 0);
      if (m_win >= 0) begin
        m_tag  = req_tag[m_win*TW +: TW];
        m_data = req_data[m_win*DW +: DW];
        m_src  = m_win;
        m_ptr  = (m_win + 1) % N;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; req_valid = '0; req_tag = '0; req_data = '0;
    for (int c = 0; c < 2; c++) begin
      at_neg();
      n_checks++;
      if (req_ready !== 4'b0000) $display("FAIL rst_ready got=%b want=0000", req_ready);
      else n_pass++;
      at_pos();
      n_checks++;
      if (cdb_valid !== 1'b0 || cdb_tag !== 4'd0 || cdb_data !== 32'd0 ||
          cdb_src !== 2'd0 || grant_ptr !== 2'd0)
        $display("FAIL rst_outputs got v=%b t=%h d=%h s=%0d p=%0d want all zero",
                 cdb_valid, cdb_tag, cdb_data, cdb_src, grant_ptr);
      else n_pass++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      at_neg();
      n_checks++;
      if (req_ready !== 4'b0000) $display("FAIL idle_ready got=%b want=0000", req_ready);
      else n_pass++;
      at_pos();
      n_checks++;
      if (cdb_valid !== 1'b0 || grant_ptr !== 2'd0)
        $display("FAIL idle_out got v=%b p=%0d want v=0 p=0", cdb_valid, grant_ptr);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    set_req(FU_MUL, 4'd5, 32'h0000_00AA);
    req_valid = 4'b0010;
    at_neg();
    n_checks++;
    if (req_ready !== 4'b0010) $display("FAIL single_ready got=%b want=0010", req_ready);
    else n_pass++;
    at_pos();
    req_valid = '0;
    n_checks++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 4'd5 || cdb_data !== 32'hAA ||
        cdb_src !== 2'd1 || grant_ptr !== 2'd2)
      $display("FAIL single_bus got v=%b t=%0d d=%h s=%0d p=%0d want v=1 t=5 d=aa s=1 p=2",
               cdb_valid, cdb_tag, cdb_data, cdb_src, grant_ptr);
    else n_pass++;
  endtask

  task automatic test_all_valid();
    int seq[5];
    seq = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    at_neg(); at_pos();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, TW'(4'(i + 8)), $urandom);
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      at_neg();
      n_checks++;
      if (req_ready !== exp_ready(seq[c]))
        $display("FAIL rr_ready cyc=%0d got=%b want=%b", c, req_ready, exp_ready(seq[c]));
      else n_pass++;
      at_pos();
      n_checks++;
      if (cdb_valid !== 1'b1 || int'(cdb_src) != seq[c] ||
          cdb_tag !== req_tag[seq[c]*TW +: TW] || cdb_data !== req_data[seq[c]*DW +: DW])
        $display("FAIL rr_bus cyc=%0d got v=%b s=%0d t=%0d want v=1 s=%0d t=%0d",
                 c, cdb_valid, cdb_src, cdb_tag, seq[c], req_tag[seq[c]*TW +: TW]);
      else n_pass++;
    end
    req_valid = '0;
  endtask

  task automatic test_wrap();
    set_req(FU_LD, 4'd3, 32'h33);
    req_valid = 4'b0100;
    at_neg(); at_pos();
    n_checks++;
    if (grant_ptr !== 2'd3) $display("FAIL wrap_setup got ptr=%0d want=3", grant_ptr);
    else n_pass++;
    set_req(FU_ADD, 4'd1, 32'h11);
    req_valid = 4'b0101;
    at_neg();
    n_checks++;
    if (req_ready !== 4'b0001) $display("FAIL wrap_ready0 got=%b want=0001", req_ready);
    else n_pass++;
    at_pos();
    n_checks++;
    if (grant_ptr !== 2'd1 || cdb_src !== 2'd0 || cdb_tag !== 4'd1)
      $display("FAIL wrap_bus0 got p=%0d s=%0d t=%0d want p=1 s=0 t=1", grant_ptr, cdb_src, cdb_tag);
    else n_pass++;
    req_valid = 4'b0100;
    at_neg();
    n_checks++;
    if (req_ready !== 4'b0100) $display("FAIL wrap_ready2 got=%b want=0100", req_ready);
    else n_pass++;
    at_pos();
    n_checks++;
    if (grant_ptr !== 2'd3 || cdb_src !== 2'd2 || cdb_tag !== 4'd3)
      $display("FAIL wrap_bus2 got p=%0d s=%0d t=%0d want p=3 s=2 t=3", grant_ptr, cdb_src, cdb_tag);
    else n_pass++;
    req_valid = '0;
  endtask

  task automatic test_flush();
    set_req(FU_LD, 4'd9, 32'hDEAD_0009);
    req_valid = 4'b0100;
    at_neg();
    n_checks++;
    if (req_ready !== 4'b0100) $display("FAIL flush_pre_ready got=%b want=0100", req_ready);
    else n_pass++;
    at_pos();
    flush = 1'b1;
    req_valid = 4'b1111;
    at_neg();
    n_checks++;
    if (req_ready !== 4'b0000 || cdb_valid !== 1'b1 || cdb_tag !== 4'd9 || cdb_src !== 2'd2)
      $display("FAIL flush_cycle got r=%b v=%b t=%0d s=%0d want r=0000 v=1 t=9 s=2",
               req_ready, cdb_valid, cdb_tag, cdb_src);
    else n_pass++;
    at_pos();
    n_checks++;
    if (cdb_valid !== 1'b0 || grant_ptr !== 2'd3)
      $display("FAIL flush_after got v=%b p=%0d want v=0 p=3", cdb_valid, grant_ptr);
    else n_pass++;
    flush = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    set_req(FU_ADD, 4'd7, 32'h7777);
    req_valid = 4'b0001;
    at_neg(); at_pos();
    n_checks++;
    if (cdb_valid !== 1'b1 || grant_ptr !== 2'd1)
      $display("FAIL rmid_grant got v=%b p=%0d want v=1 p=1", cdb_valid, grant_ptr);
    else n_pass++;
    rst_n = 1'b0; flush = 1'b1; req_valid = 4'b1111;
    at_neg();
    n_checks++;
    if (req_ready !== 4'b0000) $display("FAIL rmid_ready got=%b want=0000", req_ready);
    else n_pass++;
    at_pos();
    n_checks++;
    if (cdb_valid !== 1'b0 || grant_ptr !== 2'd0 || cdb_tag !== 4'd0 ||
        cdb_data !== 32'd0 || cdb_src !== 2'd0)
      $display("FAIL rmid_out got v=%b p=%0d t=%0d d=%h s=%0d want all zero",
               cdb_valid, grant_ptr, cdb_tag, cdb_data, cdb_src);
    else n_pass++;
    rst_n = 1'b1; flush = 1'b0; req_valid = '0;
  endtask

  task automatic test_random();
    int wait_cnt[N];
    int g;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom % 3 == 0)) begin
          req_valid[i] = 1'b1;
          set_req(i, TW'($urandom), $urandom);
        end
      end
      flush = ($urandom % 10 == 0);
      rst_n = ($urandom % 50 != 0);
      at_neg();
      n_checks++;
      if (req_ready !== exp_ready(m_win))
        $display("FAIL rand_ready cyc=%0d got=%b want=%b", c, req_ready, exp_ready(m_win));
      else n_pass++;
      g = m_win;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if (g == i) begin
            n_checks++;
            if (wait_cnt[i] > N - 1)
              $display("FAIL rand_fair fu=%0d waited=%0d limit=%0d", i, wait_cnt[i], N - 1);
            else n_pass++;
            wait_cnt[i] = 0;
          end else if (rst_n && !flush) begin
            wait_cnt[i]++;
          end
        end
      end
      at_pos();
      n_checks++;
      if (cdb_valid !== m_valid || int'(grant_ptr) != m_ptr ||
          (m_valid && (cdb_tag !== m_tag || cdb_data !== m_data || int'(cdb_src) != m_src)))
        $display("FAIL rand_bus cyc=%0d got v=%b p=%0d s=%0d t=%0d d=%h want v=%b p=%0d s=%0d t=%0d d=%h",
                 c, cdb_valid, grant_ptr, cdb_src, cdb_tag, cdb_data,
                 m_valid, m_ptr, m_src, m_tag, m_data);
      else n_pass++;
      if (g >= 0) req_valid[g] = 1'b0;
      if (flush || !rst_n) begin
        req_valid = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      end
    end
    flush = 1'b0; rst_n = 1'b1; req_valid = '0;
  endtask

  initial begin
    m_ptr = 0; m_valid = 0; m_tag = '0; m_data = '0; m_src = 0; m_win = -1;
    test_reset();
    test_single();
    test_all_valid();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Round-robin arbiter for the common data bus (CDB) that writes results into the reorder buffer and wakes up the reservation stations. Functional units (adder, multiplier, load unit, branch unit) each present one completed result. The arbiter grants at most one per cycle and broadcasts the winner's ROB tag and value on a registered bus. A flush input kills all pending and in-flight broadcasts when a mispredicted branch commits.

Parameters:
NUM_REQ, 4, number of functional-unit requesters (2..8)
DATA_W, 32, result value width
TAG_W, 4, ROB index width (16-entry ROB)
SRC_W, 2, width of requester index; must be at least clog2(NUM_REQ)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
flush  input  1  misprediction flush from ROB commit; active high, one or more cycles
req_valid  input  NUM_REQ  per-FU result-valid flag
req_tag  input  NUM_REQ*TAG_W  per-FU ROB index, requester i at bits [i*TAG_W +: TAG_W]
req_data  input  NUM_REQ*DATA_W  per-FU result value, packed the same way
req_ready  output  NUM_REQ  per-FU grant/accept (combinational)
cdb_valid  output  1  broadcast valid (registered)
cdb_tag  output  TAG_W  broadcast ROB index
cdb_data  output  DATA_W  broadcast value
cdb_src  output  SRC_W  index of the granted requester
grant_ptr  output  SRC_W  current round-robin priority pointer, for debug and verification

Behaviour:
- Reset (rst_n=0 at a clock edge): cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, grant_ptr=0. req_ready is all 0 while rst_n=0. Reset mid-transfer discards the registered broadcast.
- Handshake: a transfer on requester i occurs in a cycle where req_valid[i]=1 and req_ready[i]=1. A requester holds valid, tag and data stable until it sees ready. Valid never depends on ready.
- Grant (combinational):
  - Search requesters starting at grant_ptr, ascending, wrapping modulo NUM_REQ.
  - The first one with req_valid=1 wins; req_ready is one-hot or zero.
  - If flush=1 or rst_n=0, req_ready is all 0.
- Latency: exactly 1 cycle. A transfer in cycle N produces cdb_valid=1 with that tag/data/src in cycle N+1.
- Output when no transfer occurs: cdb_valid=0 the next cycle. cdb_tag, cdb_data and cdb_src hold their last values (don't-care when invalid).
- Pointer: after a transfer from requester i, grant_ptr = (i+1) mod NUM_REQ. The pointer is unchanged when there is no transfer. The pointer is not affected by flush.
- Flush:
  - Asserted in cycle N: no grant in N, and cdb_valid=0 in N+1, even if a transfer was registered in N-1.
  - That means a broadcast that would appear in N+1 is suppressed, and a broadcast already visible in N stays visible in N.
  - Requesters keep their valid asserted. They are expected to drop it themselves on flush; the arbiter does not track them.
- Throughput: one broadcast per cycle, back-to-back with no bubble.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 cycles for a grant.
- Simultaneous flush and reset: reset dominates; the outputs take their reset values.
- Width rules: the pointer increment wraps explicitly at NUM_REQ. Do not rely on SRC_W overflow when NUM_REQ is not a power of 2.

Decomposition:
- Shared package (tomasulo_pkg): ROB_TAG_W=4, XLEN=32, and the FU index constants FU_ADD=0, FU_MUL=1, FU_LD=2, FU_BR=3.
- One sub-module: rr_pick (combinational rotate, priority pick, and one-hot output, parameterised on NUM_REQ). The top level holds only the pointer and output registers.

Test Plan:
- Reset release, no requests -> cdb_valid=0, grant_ptr=0, req_ready=0000 for 5 cycles.
- Single req_valid=0010 with tag=5, data=0x0000_00AA -> req_ready=0010 the same cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_data=0xAA, cdb_src=1; grant_ptr=2.
- All four valid continuously from grant_ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; cdb_valid stays 1 with no bubbles.
- grant_ptr=3, req_valid=0101 -> grant 0, then 2 (wrap-around); grant_ptr goes 3→1→3.
- Grant to FU 2 in cycle N, flush=1 in cycle N+1 with req_valid=1111 -> cdb_valid=1 in N+1 (tag from FU 2), req_ready=0000 in N+1, cdb_valid=0 in N+2, grant_ptr still 3.
- rst_n=0 in the cycle after a grant -> next cycle cdb_valid=0, grant_ptr=0, cdb_tag=0, cdb_data=0.
